axi4_lite_slave_mem: RTL and testbench

AXI4-Lite slave memory that terminates the single-cycle core's AXI4-Lite master port, acting as the downstream data-memory stage. It accepts independent read and write transactions, stores `DEPTH` 32-bit words with byte-strobe writes, and returns OKAY/SLVERR responses. The read and write channels run concurrently under two separate FSMs that share one storage array.

---
 rtl/axi4_lite_pkg.sv | 25 ++
 rtl/axi4_lite_slave_regfile.sv | 37 +++
 rtl/axi4_lite_slave_mem.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_slave_mem.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite slave memory.
// Response codes, channel FSM state types and the fixed data/strobe widths.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regfile.sv
// Word storage for the AXI4-Lite slave: one byte-strobe write port, one
// asynchronous read port, cleared asynchronously on reset.
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory: independent read and write channel FSMs sharing one
// word array, with range checking that turns out-of-range accesses into SLVERR.
module axi4_lite_slave_mem
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic [ADDRESS-1:0]    S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,

    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY,

    input  logic [ADDRESS-1:0]    S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,

    input  logic [DATA_WIDTH-1:0] S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,

    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY
);

    localparam int unsigned        IDX_W      = $clog2(DEPTH);
    localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(DEPTH * 4);

    // ---------------------------------------------------------------- write
    wr_state_t               r_wstate;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [ADDRESS-1:0]      r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;
    logic [1:0]              r_bresp;

    logic                    w_awready;
    logic                    w_wready;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_commit;
    logic [ADDRESS-1:0]      w_commit_addr;
    logic [DATA_WIDTH-1:0]   w_commit_data;
    logic [3:0]              w_commit_strb;
    logic                    w_wr_in_range;
    logic                    w_mem_we;

    assign w_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_hs   = S_AWVALID && w_awready;
    assign w_w_hs    = S_WVALID && w_wready;

    // A handshake on the commit edge itself supplies its payload directly,
    // so AW and W in the same cycle commit without an extra capture cycle.
    assign w_commit_addr = r_aw_held ? r_awaddr : S_AWADDR;
    assign w_commit_data = r_w_held  ? r_wdata  : S_WDATA;
    assign w_commit_strb = r_w_held  ? r_wstrb  : S_WSTRB;
    assign w_commit      = (r_wstate == W_IDLE)
                         && (r_aw_held || w_aw_hs)
                         && (r_w_held  || w_w_hs);
    assign w_wr_in_range = w_commit_addr < ADDR_LIMIT;
    assign w_mem_we      = w_commit && w_wr_in_range;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= resp_for(w_wr_in_range);
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= S_AWADDR;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= S_WDATA;
                            r_wstrb  <= S_WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (S_BREADY) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign S_AWREADY = w_awready;
    assign S_WREADY  = w_wready;
    assign S_BVALID  = (r_wstate == W_RESP);
    assign S_BRESP   = r_bresp;

    // ----------------------------------------------------------------- read
    rd_state_t               r_rstate;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_arready;
    logic                    w_ar_hs;
    logic                    w_rd_in_range;
    logic [DATA_WIDTH-1:0]   w_mem_rdata;

    assign w_arready     = (r_rstate == R_IDLE);
    assign w_ar_hs       = S_ARVALID && w_arready;
    assign w_rd_in_range = S_ARADDR < ADDR_LIMIT;

    // The array is sampled before any same-edge commit lands, so a
    // concurrent read of the word being written returns the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_DATA;
                        r_rdata  <= w_rd_in_range ? w_mem_rdata : '0;
                        r_rresp  <= resp_for(w_rd_in_range);
                    end
                end
                R_DATA: begin
                    if (S_RREADY) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_ARREADY = w_arready;
    assign S_RVALID  = (r_rstate == R_DATA);
    assign S_RDATA   = r_rdata;
    assign S_RRESP   = r_rresp;

    // -------------------------------------------------------------- storage
    axi4_lite_slave_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_we    (w_mem_we),
        .i_waddr (w_commit_addr[2 +: IDX_W]),
        .i_wdata (w_commit_data),
        .i_wstrb (w_commit_strb),
        .i_raddr (S_ARADDR[2 +: IDX_W]),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Self-checking bench for axi4_lite_slave_mem: directed scenarios plus random
// traffic checked against a word-array reference model.
module tb_axi4_lite_slave_mem;

    localparam int DEPTH = 64;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];

    always #5 ACLK = ~ACLK;

    axi4_lite_slave_mem #(
        .ADDRESS    (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY)
    );

    // ------------------------------------------------------ reference model
    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_range(a) ? model[a / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // ------------------------------------------------------ bus drivers
    // All drivers start and end just after a falling edge.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic rv_n1,
                            output logic arready_n2, output logic timeout);
        int cyc;
        cyc = 0;
        S_ARADDR  = addr;
        S_ARVALID = 1'b1;
        S_RREADY  = 1'b1;
        while (!S_ARREADY && cyc < 60) begin
            @(negedge ACLK);
            cyc++;
        end
        timeout = !S_ARREADY;
        @(negedge ACLK);
        S_ARVALID  = 1'b0;
        rv_n1      = S_RVALID;
        data       = S_RDATA;
        resp       = S_RRESP;
        @(negedge ACLK);
        arready_n2 = S_ARREADY;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic bv_n1,
                             output logic bv_done, output logic early,
                             output logic timeout);
        int   cyc;
        logic aw_done, w_done, aw_f, w_f;
        cyc = 0; aw_done = 0; w_done = 0; early = 0;
        S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb; S_BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 60) begin
            S_AWVALID = !aw_done && (cyc >= aw_dly);
            S_WVALID  = !w_done && (cyc >= w_dly);
            aw_f = S_AWVALID && S_AWREADY;
            w_f  = S_WVALID && S_WREADY;
            @(negedge ACLK);
            cyc++;
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            if (!(aw_done && w_done) && S_BVALID) early = 1'b1;
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        timeout   = !(aw_done && w_done);
        bv_n1     = S_BVALID;
        resp      = S_BRESP;
        @(negedge ACLK);
        bv_done   = S_BVALID;
    endtask

    // ------------------------------------------------------ scenarios
    task automatic test_reset();
        logic [40:0] got;
        ARESETN = 1'b0;
        S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
        S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0; S_BREADY = 0;
        model_clear();
        #12;
        got = {S_ARREADY, S_AWREADY, S_WREADY, S_RVALID, S_BVALID, S_RRESP, S_BRESP, S_RDATA};
        checks++;
        if (got !== {5'b11100, 2'b00, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", got, {5'b11100, 2'b00, 2'b00, 32'h0});
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_basic_write_read();
        logic [31:0] d; logic [1:0] r; logic a, b, c, e, t;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, a, b, e, t);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({t, e, a, r, b} !== {1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL basic_write to=%b early=%b bvalid_n1=%b bresp=%b bvalid_after=%b exp 0 0 1 00 0", t, e, a, r, b);
        end
        axi_read(32'h10, d, r, a, c, t);
        checks++;
        if ({t, a, r, d, c} !== {1'b0, 1'b1, 2'b00, model_read(32'h10), 1'b1}) begin
            errors++;
            $display("FAIL basic_read to=%b rvalid_n1=%b rresp=%b rdata=%h arready_n2=%b exp rdata=%h",
                     t, a, r, d, c, model_read(32'h10));
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; logic a, b, c, e, t;
        axi_write(32'h20, 32'h11223344, 4'b0101, 0, 0, r, a, b, e, t);
        model_write(32'h20, 32'h11223344, 4'b0101);
        checks++;
        if ({t, a, r} !== {1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL strobe_write to=%b bvalid_n1=%b bresp=%b", t, a, r);
        end
        axi_read(32'h20, d, r, a, c, t);
        checks++;
        if ({t, a, r, d} !== {1'b0, 1'b1, 2'b00, model_read(32'h20)}) begin
            errors++;
            $display("FAIL strobe_read rdata=%h exp=%h rresp=%b", d, model_read(32'h20), r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r; logic a, c, t;
        S_WDATA = 32'hA5A5A5A5; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b1;
        checks++;
        if (S_WREADY !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_wready_idle got=%b exp=1", S_WREADY);
        end
        @(negedge ACLK);
        S_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                S_AWADDR = 32'h08; S_AWVALID = 1'b1;
            end
            checks++;
            if ({S_WREADY, S_BVALID, S_AWREADY} !== 3'b001) begin
                errors++;
                $display("FAIL wfirst_wait[%0d] wready=%b bvalid=%b awready=%b exp 0 0 1",
                         i, S_WREADY, S_BVALID, S_AWREADY);
            end
            @(negedge ACLK);
        end
        S_AWVALID = 1'b0;
        model_write(32'h08, 32'hA5A5A5A5, 4'hF);
        checks++;
        if ({S_BVALID, S_BRESP} !== 3'b100) begin
            errors++;
            $display("FAIL wfirst_bresp bvalid=%b bresp=%b exp 1 00", S_BVALID, S_BRESP);
        end
        @(negedge ACLK);
        checks++;
        if ({S_BVALID, S_AWREADY, S_WREADY} !== 3'b011) begin
            errors++;
            $display("FAIL wfirst_done bvalid=%b awready=%b wready=%b exp 0 1 1", S_BVALID, S_AWREADY, S_WREADY);
        end
        axi_read(32'h08, d, r, a, c, t);
        checks++;
        if ({t, a, r, d} !== {1'b0, 1'b1, 2'b00, model_read(32'h08)}) begin
            errors++;
            $display("FAIL wfirst_read rdata=%h exp=%h", d, model_read(32'h08));
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; logic a, b, c, e, t;
        axi_read(32'h100, d, r, a, c, t);
        checks++;
        if ({t, a, r, d} !== {1'b0, 1'b1, 2'b10, 32'h0}) begin
            errors++;
            $display("FAIL oor_read rresp=%b rdata=%h exp 10 00000000", r, d);
        end
        axi_write(32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, r, a, b, e, t);
        checks++;
        if ({t, a, r, b} !== {1'b0, 1'b1, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL oor_write bvalid_n1=%b bresp=%b exp 1 10", a, r);
        end
        for (int i = 0; i < DEPTH; i++) begin
            axi_read(32'(i * 4), d, r, a, c, t);
            checks++;
            if ({t, r, d} !== {1'b0, 2'b00, model[i]}) begin
                errors++;
                $display("FAIL oor_sweep[%0d] rdata=%h exp=%h rresp=%b", i, d, model[i], r);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r, wd;
        exp_r = model_read(32'h10);
        wd    = $urandom;
        S_RREADY = 1'b0; S_BREADY = 1'b0;
        S_ARADDR = 32'h10; S_ARVALID = 1'b1;
        S_AWADDR = 32'h30; S_AWVALID = 1'b1; S_WDATA = wd; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        @(negedge ACLK);
        model_write(32'h30, wd, 4'hF);
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        S_ARADDR = 32'h30;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({S_RVALID, S_RDATA, S_RRESP, S_BVALID, S_BRESP, S_ARREADY}
                !== {1'b1, exp_r, 2'b00, 1'b1, 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d] rvalid=%b rdata=%h rresp=%b bvalid=%b bresp=%b arready=%b exp rdata=%h",
                         i, S_RVALID, S_RDATA, S_RRESP, S_BVALID, S_BRESP, S_ARREADY, exp_r);
            end
            @(negedge ACLK);
        end
        S_RREADY = 1'b1; S_BREADY = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({S_RVALID, S_BVALID, S_ARREADY} !== 3'b001) begin
            errors++;
            $display("FAIL hold_release rvalid=%b bvalid=%b arready=%b exp 0 0 1", S_RVALID, S_BVALID, S_ARREADY);
        end
        @(negedge ACLK);
        S_ARVALID = 1'b0;
        checks++;
        if ({S_RVALID, S_RDATA} !== {1'b1, model_read(32'h30)}) begin
            errors++;
            $display("FAIL hold_next_ar rvalid=%b rdata=%h exp 1 %h", S_RVALID, S_RDATA, model_read(32'h30));
        end
        @(negedge ACLK);
    endtask

    task automatic test_read_during_commit();
        logic [31:0] old_d, new_d, d; logic [1:0] r; logic a, c, t;
        old_d = model_read(32'h18);
        new_d = ~old_d;
        S_ARADDR = 32'h18; S_ARVALID = 1'b1; S_RREADY = 1'b1;
        S_AWADDR = 32'h18; S_AWVALID = 1'b1; S_WDATA = new_d; S_WSTRB = 4'hF; S_WVALID = 1'b1; S_BREADY = 1'b1;
        @(negedge ACLK);
        S_ARVALID = 1'b0; S_AWVALID = 1'b0; S_WVALID = 1'b0;
        checks++;
        if ({S_RVALID, S_RDATA, S_BVALID, S_BRESP} !== {1'b1, old_d, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL same_edge rvalid=%b rdata=%h bvalid=%b bresp=%b exp rdata=%h",
                     S_RVALID, S_RDATA, S_BVALID, S_BRESP, old_d);
        end
        model_write(32'h18, new_d, 4'hF);
        @(negedge ACLK);
        axi_read(32'h18, d, r, a, c, t);
        checks++;
        if ({t, a, d} !== {1'b0, 1'b1, new_d}) begin
            errors++;
            $display("FAIL same_edge_after rdata=%h exp=%h", d, new_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        S_RREADY  = 1'b1;
        S_ARADDR  = 32'h0;
        S_ARVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = S_ARADDR;
            checks++;
            if (S_ARREADY !== 1'b1) begin
                errors++;
                $display("FAIL b2b_arready[%0d] got=%b exp=1", i, S_ARREADY);
            end
            @(negedge ACLK);
            S_ARADDR = 32'((i + 1) * 4);
            if (i == 3) S_ARVALID = 1'b0;
            checks++;
            if ({S_RVALID, S_RDATA, S_ARREADY} !== {1'b1, model_read(addr), 1'b0}) begin
                errors++;
                $display("FAIL b2b_data[%0d] rvalid=%b rdata=%h arready=%b exp 1 %h 0",
                         i, S_RVALID, S_RDATA, S_ARREADY, model_read(addr));
            end
            @(negedge ACLK);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [1:0] r; logic a, b, c, e, t;
        S_ARADDR = 32'h10; S_ARVALID = 1'b1; S_RREADY = 1'b0;
        S_AWADDR = 32'h40; S_AWVALID = 1'b1; S_BREADY = 1'b1;
        @(negedge ACLK);
        S_ARVALID = 1'b0; S_AWVALID = 1'b0;
        checks++;
        if ({S_RVALID, S_AWREADY, S_WREADY, S_BVALID} !== 4'b1010) begin
            errors++;
            $display("FAIL pre_reset rvalid=%b awready=%b wready=%b bvalid=%b exp 1 0 1 0",
                     S_RVALID, S_AWREADY, S_WREADY, S_BVALID);
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({S_ARREADY, S_AWREADY, S_WREADY, S_RVALID, S_BVALID, S_RRESP, S_BRESP, S_RDATA}
            !== {5'b11100, 2'b00, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL async_reset arready=%b awready=%b wready=%b rvalid=%b bvalid=%b rdata=%h",
                     S_ARREADY, S_AWREADY, S_WREADY, S_RVALID, S_BVALID, S_RDATA);
        end
        model_clear();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        S_RREADY = 1'b1;
        @(negedge ACLK);
        for (int i = 0; i < DEPTH; i++) begin
            axi_read(32'(i * 4), d, r, a, c, t);
            checks++;
            if ({t, r, d} !== {1'b0, 2'b00, 32'h0}) begin
                errors++;
                $display("FAIL post_reset_clear[%0d] rdata=%h exp=00000000", i, d);
            end
        end
        // W leads AW so a stale captured address would commit early.
        axi_write(32'h44, 32'hC0FFEE11, 4'hF, 2, 0, r, a, b, e, t);
        model_write(32'h44, 32'hC0FFEE11, 4'hF);
        checks++;
        if ({t, e, a, r, b} !== {1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_write to=%b early=%b bvalid_n1=%b bresp=%b bvalid_after=%b", t, e, a, r, b);
        end
        axi_read(32'h44, d, r, a, c, t);
        checks++;
        if ({t, a, r, d} !== {1'b0, 1'b1, 2'b00, model_read(32'h44)}) begin
            errors++;
            $display("FAIL post_reset_read rdata=%h exp=%h", d, model_read(32'h44));
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, d; logic [3:0] s; logic [1:0] r; logic a, b, c, e, t;
        int aw_dly, w_dly;
        for (int i = 0; i < 80; i++) begin
            addr = ($urandom_range(0, DEPTH + 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; s = 4'($urandom_range(0, 15));
                aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
                axi_write(addr, wd, s, aw_dly, w_dly, r, a, b, e, t);
                model_write(addr, wd, s);
                checks++;
                if ({t, e, a, r, b} !== {1'b0, 1'b0, 1'b1, exp_resp(addr), 1'b0}) begin
                    errors++;
                    $display("FAIL rand_write[%0d] addr=%h to=%b early=%b bvalid_n1=%b bresp=%b exp %b",
                             i, addr, t, e, a, r, exp_resp(addr));
                end
            end else begin
                axi_read(addr, d, r, a, c, t);
                checks++;
                if ({t, a, r, d, c} !== {1'b0, 1'b1, exp_resp(addr), model_read(addr), 1'b1}) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr=%h rdata=%h rresp=%b exp %h %b",
                             i, addr, d, r, model_read(addr), exp_resp(addr));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write_read();
        test_strobe();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_read_during_commit();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
